regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters: A is the ALU result path and B is the load/memory path.
- Arbitrates round-robin with valid/ready handshakes and registers the winning write into a one-cycle writeback stage.
- Keeps a per-register pending scoreboard that decode uses to stall reads of registers with writes still in flight.
- Sits between the execute/memory stages and register_file.

---
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the regfile write port,
// a one-cycle writeback stage and a per-register pending scoreboard.
// Ports: a_*/b_* valid/ready requesters; we3/a3/wd3 regfile write port;
// issue_* sets pending bits; rs1/rs2 -> stall_rs1/stall_rs2; sb_err sticky.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int FIX_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              stall_rs1,
  output logic              stall_rs2,
  output logic              sb_err
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e           r_prio;
  prio_e           w_prio_nxt;
  logic            w_acc_a;
  logic            w_acc_b;
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_err_set;

  always_comb begin
    a_ready = !b_valid ||
              (r_prio == PRIO_A && FIX_PRIO == 0);
    b_ready = !a_valid ||
              r_prio == PRIO_B ||
              FIX_PRIO == 1;
    w_acc_a = a_valid && a_ready;
    w_acc_b = b_valid && b_ready;
  end

  // The loser of an accept gets priority next time.
  always_comb begin
    w_prio_nxt = r_prio;
    if (w_acc_a)
      w_prio_nxt = PRIO_B;
    else if (w_acc_b)
      w_prio_nxt = PRIO_A;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_prio <= PRIO_A;
    else
      r_prio <= w_prio_nxt;
  end

  // x0 writes are consumed but never reach the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (w_acc_a) begin
      we3 <= (a_rd != '0);
      a3  <= a_rd;
      wd3 <= a_data;
    end else if (w_acc_b) begin
      we3 <= (b_rd != '0);
      a3  <= b_rd;
      wd3 <= b_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  // Set after clear: a same-cycle issue means a newer
  // producer is still outstanding.
  always_comb begin
    w_pend_nxt = r_pend;
    if (we3)
      w_pend_nxt[a3] = 1'b0;
    if (issue_valid)
      w_pend_nxt[issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_err_set = we3 && (a3 != '0) &&
                !r_pend[a3] &&
                !(issue_valid && issue_rd == a3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      sb_err <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_err_set)
        sb_err <= 1'b1;
    end
  end

  // No bypass: stall holds through the commit cycle.
  always_comb begin
    stall_rs1 = r_pend[rs1];
    stall_rs2 = r_pend[rs2];
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter.
// Writes are queued on modelled accept and popped on we3.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid, b_valid, issue_valid;
  logic [AW-1:0] a_rd, b_rd, issue_rd, rs1, rs2;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          stall_rs1, stall_rs2, sb_err;

  logic          fp_a_ready, fp_b_ready, fp_we3;
  logic [AW-1:0] fp_a3;
  logic [DW-1:0] fp_wd3;
  logic          fp_stall_rs1, fp_stall_rs2, fp_sb_err;

  int  n_chk  = 0;
  int  n_fail = 0;
  wb_t q[$];
  wb_t e;
  bit  m_prio;
  logic ea, eb;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIX_PRIO(0)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_rd(b_rd), .b_data(b_data),
    .we3(we3), .a3(a3), .wd3(wd3),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2),
    .stall_rs1(stall_rs1), .stall_rs2(stall_rs2),
    .sb_err(sb_err)
  );

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIX_PRIO(1)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(fp_a_ready),
    .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(fp_b_ready),
    .b_rd(b_rd), .b_data(b_data),
    .we3(fp_we3), .a3(fp_a3), .wd3(fp_wd3),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2),
    .stall_rs1(fp_stall_rs1), .stall_rs2(fp_stall_rs2),
    .sb_err(fp_sb_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  // Monitor + model: pop on commit, then push on modelled accept.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      m_prio = 1'b0;
    end else begin
      if (we3) begin
        if (q.size() == 0) begin
          chk("wb_unexp", {63'd0, we3}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("wb_a3", {59'd0, a3}, {59'd0, e.rd});
          chk("wb_wd3", {32'd0, wd3}, {32'd0, e.data});
        end
      end
      if (a_valid || b_valid) begin
        ea = !b_valid || !m_prio;
        eb = !a_valid || m_prio;
        chk("arb_a_rdy", {63'd0, a_ready}, {63'd0, ea});
        chk("arb_b_rdy", {63'd0, b_ready}, {63'd0, eb});
        if (a_valid && ea) begin
          if (a_rd != '0) q.push_back('{a_rd, a_data});
          m_prio = 1'b1;
        end else if (b_valid && eb) begin
          if (b_rd != '0) q.push_back('{b_rd, b_data});
          m_prio = 1'b0;
        end
      end
    end
  end

  initial begin
    a_valid = 0; b_valid = 0; issue_valid = 0;
    a_rd = 0; b_rd = 0; issue_rd = 0;
    a_data = 0; b_data = 0;
    rs1 = 5; rs2 = 6;

    // reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #2;
    chk("rst_we3", {63'd0, we3}, 0);
    chk("rst_a3", {59'd0, a3}, 0);
    chk("rst_wd3", {32'd0, wd3}, 0);
    chk("rst_stall1", {63'd0, stall_rs1}, 0);
    chk("rst_stall2", {63'd0, stall_rs2}, 0);
    chk("rst_err", {63'd0, sb_err}, 0);

    // contention, round-robin
    @(posedge clk); #1 issue_valid = 1; issue_rd = 6;
    @(posedge clk); #1 issue_rd = 7;
    @(posedge clk); #1 issue_rd = 8;
    @(posedge clk); #1 issue_valid = 0;
    a_valid = 1; a_rd = 6; a_data = 32'hA;
    b_valid = 1; b_rd = 7; b_data = 32'h28;
    rs1 = 6; rs2 = 7;
    #2;
    chk("rr1_a_rdy", {63'd0, a_ready}, 1);
    chk("rr1_b_rdy", {63'd0, b_ready}, 0);
    chk("fp_a_rdy", {63'd0, fp_a_ready}, 0);
    chk("fp_b_rdy", {63'd0, fp_b_ready}, 1);
    chk("rr_stall6", {63'd0, stall_rs1}, 1);
    @(posedge clk); #1 a_rd = 8; a_data = 32'h11;
    #2;
    chk("rr2_a_rdy", {63'd0, a_ready}, 0);
    chk("rr2_b_rdy", {63'd0, b_ready}, 1);
    chk("rr2_we3", {63'd0, we3}, 1);
    chk("rr2_a3", {59'd0, a3}, 6);
    @(posedge clk); #1 b_valid = 0;
    #2;
    chk("rr3_a_rdy", {63'd0, a_ready}, 1);
    chk("rr3_a3", {59'd0, a3}, 7);
    chk("rr3_stall6", {63'd0, stall_rs1}, 0);
    chk("rr3_stall7", {63'd0, stall_rs2}, 1);
    @(posedge clk); #1 a_valid = 0;
    #2;
    chk("rr4_a3", {59'd0, a3}, 8);
    @(posedge clk); #3;
    chk("rr5_we3", {63'd0, we3}, 0);
    chk("rr5_stall7", {63'd0, stall_rs2}, 0);
    chk("rr5_err", {63'd0, sb_err}, 0);

    // single A write
    @(posedge clk); #1 issue_valid = 1; issue_rd = 5; rs1 = 5;
    @(posedge clk); #1 issue_valid = 0;
    a_valid = 1; a_rd = 5; a_data = 32'h6;
    #2;
    chk("a_rdy", {63'd0, a_ready}, 1);
    chk("a_stall_pend", {63'd0, stall_rs1}, 1);
    @(posedge clk); #1 a_valid = 0;
    #2;
    chk("a_we3", {63'd0, we3}, 1);
    chk("a_a3", {59'd0, a3}, 5);
    chk("a_wd3", {32'd0, wd3}, 32'h6);
    chk("a_nobypass", {63'd0, stall_rs1}, 1);
    @(posedge clk); #3;
    chk("a_stall_clr", {63'd0, stall_rs1}, 0);
    chk("a_err", {63'd0, sb_err}, 0);

    // x0 suppression
    @(posedge clk); #1 a_valid = 1; a_rd = 0; a_data = '1;
    #2 chk("x0_rdy", {63'd0, a_ready}, 1);
    @(posedge clk); #1 a_valid = 0;
    #2;
    chk("x0_we3", {63'd0, we3}, 0);
    chk("x0_err", {63'd0, sb_err}, 0);

    // same-cycle set/clear
    @(posedge clk); #1 issue_valid = 1; issue_rd = 9; rs2 = 9;
    @(posedge clk); #1 issue_valid = 0;
    a_valid = 1; a_rd = 9; a_data = 32'h99;
    @(posedge clk); #1 a_valid = 0;
    issue_valid = 1; issue_rd = 9;
    #2;
    chk("sc_we3", {63'd0, we3}, 1);
    chk("sc_a3", {59'd0, a3}, 9);
    @(posedge clk); #1 issue_valid = 0;
    #2;
    chk("sc_stall", {63'd0, stall_rs2}, 1);
    chk("sc_err", {63'd0, sb_err}, 0);
    @(posedge clk); #1 a_valid = 1; a_rd = 9; a_data = 32'h9A;
    @(posedge clk); #1 a_valid = 0;
    @(posedge clk); #3;
    chk("sc_stall_clr", {63'd0, stall_rs2}, 0);
    chk("sc_err2", {63'd0, sb_err}, 0);

    // error: commit to a register never issued
    @(posedge clk); #1 b_valid = 1; b_rd = 12; b_data = 32'h55;
    #2 chk("err_b_rdy", {63'd0, b_ready}, 1);
    @(posedge clk); #1 b_valid = 0;
    #2;
    chk("err_we3", {63'd0, we3}, 1);
    chk("err_a3", {59'd0, a3}, 12);
    chk("err_pre", {63'd0, sb_err}, 0);
    @(posedge clk); #3;
    chk("err_set", {63'd0, sb_err}, 1);

    // reset mid-transfer
    @(posedge clk); #1 a_valid = 1; a_rd = 5; a_data = 32'h77;
    #1 rst = 0;
    #1;
    chk("mr_we3", {63'd0, we3}, 0);
    chk("mr_err", {63'd0, sb_err}, 0);
    @(posedge clk); #3;
    chk("mr_we3_2", {63'd0, we3}, 0);
    chk("mr_a3", {59'd0, a3}, 0);
    chk("mr_wd3", {32'd0, wd3}, 0);
    a_valid = 0;
    rst = 1;
    @(posedge clk); #3;
    chk("mr_we3_3", {63'd0, we3}, 0);
    chk("mr_err2", {63'd0, sb_err}, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(posedge clk);
    chk("q_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
